// File: rtl/spi_display_regfile.sv
// SPI mode-3 slave register file feeding the seven-segment display interface:
// oversampled SPI pins, command/data framing, burst access and MISO read-back.
module spi_display_regfile #(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                    clock_5meg_i,
  input  logic                    rst_low_i,
  input  logic                    spi_sclk_i,
  input  logic                    spi_ss_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic [4*NUM_DIGITS-1:0] display_value_o,
  output logic [NUM_DIGITS-1:0]   display_point_o,
  output logic [NUM_DIGITS-1:0]   display_enable_o,
  output logic                    wr_strobe_o,
  output logic                    frame_err_o
);
  localparam int NUM_REGS = NUM_DIGITS + 2;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_DATA = 2'd2, ST_SKIP = 2'd3;
  localparam logic [3:0] OP_WRITE = 4'h1, OP_READ = 4'h2, OP_BWRITE = 4'h3, OP_BREAD = 4'h4;

  logic [1:0]        sclk_sync_reg, ss_sync_reg, mosi_sync_reg;
  logic              sclk_prev_reg, rise_reg, fall_reg, ss_reg, mosi_reg;
  logic [1:0]        state_reg;
  logic [2:0]        bit_cnt_reg;
  logic [6:0]        shift_reg;
  logic [7:0]        miso_sr_reg;
  logic [3:0]        op_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              wr_done_reg;
  logic [7:0]        regs_reg [NUM_REGS];

  logic [7:0]        rx_byte, rd_cmd, rd_inc;
  logic [2:0]        bit_cnt_next;
  logic [ADDR_W-1:0] ptr_inc, cmd_addr;
  logic              byte_done, miso_active, wr_en, ptr_hit;

  // Edge pulses and ss/mosi are all registered at the same depth so they line up.
  always_ff @(posedge clock_5meg_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      sclk_sync_reg <= 2'b11;
      ss_sync_reg   <= 2'b11;
      mosi_sync_reg <= 2'b00;
      sclk_prev_reg <= 1'b1;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
      ss_reg        <= 1'b1;
      mosi_reg      <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], spi_sclk_i};
      ss_sync_reg   <= {ss_sync_reg[0], spi_ss_i};
      mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi_i};
      sclk_prev_reg <= sclk_sync_reg[1];
      rise_reg      <= sclk_sync_reg[1] & ~sclk_prev_reg;
      fall_reg      <= ~sclk_sync_reg[1] & sclk_prev_reg;
      ss_reg        <= ss_sync_reg[1];
      mosi_reg      <= mosi_sync_reg[1];
    end
  end

  always_comb begin
    rx_byte      = {shift_reg, mosi_reg};
    bit_cnt_next = rise_reg ? bit_cnt_reg + 3'd1 : bit_cnt_reg;
    byte_done    = rise_reg && (bit_cnt_reg == 3'd7);
    cmd_addr     = rx_byte[ADDR_W-1:0];
    ptr_inc      = (ptr_reg == ADDR_MAX) ? ptr_reg : ptr_reg + ADDR_W'(1);
    miso_active  = (state_reg == ST_DATA) && ((op_reg == OP_READ) || (op_reg == OP_BREAD));
    wr_en        = (state_reg == ST_DATA) && byte_done &&
                   (((op_reg == OP_WRITE) && !wr_done_reg) || (op_reg == OP_BWRITE));
    // Unmapped addresses fall through the decode and read as zero.
    rd_cmd  = 8'h00;
    rd_inc  = 8'h00;
    ptr_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == ADDR_W'(i)) rd_cmd = regs_reg[i];
      if (ptr_inc == ADDR_W'(i))  rd_inc = regs_reg[i];
      if (ptr_reg == ADDR_W'(i))  ptr_hit = 1'b1;
    end
  end

  always_ff @(posedge clock_5meg_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 7'd0;
      miso_sr_reg <= 8'h00;
      op_reg      <= 4'h0;
      ptr_reg     <= '0;
      wr_done_reg <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (state_reg == ST_IDLE) begin
        bit_cnt_reg <= 3'd0;
        if (!ss_reg) state_reg <= ST_CMD;
      end else begin
        if (rise_reg) begin
          shift_reg   <= rx_byte[6:0];
          bit_cnt_reg <= bit_cnt_next;
        end
        // The first fall of a byte only launches the MSB already on the line.
        if (fall_reg && (bit_cnt_reg != 3'd0) && miso_active)
          miso_sr_reg <= {miso_sr_reg[6:0], 1'b0};
        if (byte_done) begin
          case (state_reg)
            ST_CMD: begin
              op_reg      <= rx_byte[7:4];
              ptr_reg     <= cmd_addr;
              wr_done_reg <= 1'b0;
              miso_sr_reg <= rd_cmd;
              if (rx_byte[7:4] > OP_BREAD) begin
                state_reg   <= ST_SKIP;
                frame_err_o <= 1'b1;
              end else begin
                state_reg <= ST_DATA;
              end
            end
            ST_DATA: begin
              if (op_reg == OP_WRITE) wr_done_reg <= 1'b1;
              if ((op_reg == OP_BWRITE) || (op_reg == OP_BREAD)) ptr_reg <= ptr_inc;
              miso_sr_reg <= (op_reg == OP_BREAD) ? rd_inc : 8'h00;
            end
            default: ;
          endcase
        end
        // A byte completing in the same cycle as ss release still commits cleanly.
        if (ss_reg) begin
          state_reg   <= ST_IDLE;
          bit_cnt_reg <= 3'd0;
          if ((bit_cnt_next != 3'd0) && (state_reg != ST_SKIP)) frame_err_o <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_5meg_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      wr_strobe_o <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= 8'h00;
    end else begin
      wr_strobe_o <= wr_en && ptr_hit;
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_en && (ptr_reg == ADDR_W'(i))) regs_reg[i] <= rx_byte;
    end
  end

  assign spi_miso_o = miso_active ? miso_sr_reg[7] : 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign display_value_o[4*gi +: 4] = regs_reg[gi+1][3:0];
    if (gi < 8) begin : g_bit
      assign display_point_o[gi]  = regs_reg[NUM_DIGITS+1][gi];
      assign display_enable_o[gi] = regs_reg[0][gi];
    end else begin : g_pad
      assign display_point_o[gi]  = 1'b0;
      assign display_enable_o[gi] = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_display_regfile.sv
// Directed bench for spi_display_regfile: bit-banged SPI frames against a byte-level register model.
module tb_spi_display_regfile;
  localparam int NUM_DIGITS = 8;
  localparam int NUM_REGS   = NUM_DIGITS + 2;

  logic clk = 1'b0;
  logic rst_n, sclk, ss, mosi;
  logic miso, wr_strobe, frame_err;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_point, disp_enable;

  always #5 clk = ~clk;

  spi_display_regfile #(.NUM_DIGITS(NUM_DIGITS), .ADDR_W(4)) dut (
    .clock_5meg_i    (clk),
    .rst_low_i       (rst_n),
    .spi_sclk_i      (sclk),
    .spi_ss_i        (ss),
    .spi_mosi_i      (mosi),
    .spi_miso_o      (miso),
    .display_value_o (disp_value),
    .display_point_o (disp_point),
    .display_enable_o(disp_enable),
    .wr_strobe_o     (wr_strobe),
    .frame_err_o     (frame_err)
  );

  int n_cmp = 0, n_fail = 0;
  int n_strobe = 0, n_err = 0, m_strobe = 0, m_err = 0;
  int frame_no = 0;
  bit check_en = 1'b0;
  logic [7:0] m_regs [NUM_REGS];
  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];
  logic [7:0] exp_rx [16];
  logic [31:0] exp_value;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_read(input int a);
    return (a < NUM_REGS) ? m_regs[a] : 8'h00;
  endfunction

  // Byte-level reading of the frame rules: what the registers, strobes,
  // errors and returned MISO bytes must be for the bytes just sent.
  task automatic model_frame(input int nbytes, input bit aborted);
    int  op, ptr;
    bit  first;
    for (int i = 0; i < 16; i++) exp_rx[i] = 8'hFF;
    if (nbytes > 0) begin
      op    = int'(tx_buf[0][7:4]);
      ptr   = int'(tx_buf[0][3:0]);
      first = 1'b1;
      if (op > 4) begin
        m_err++;
        return;
      end
      for (int i = 1; i < nbytes; i++) begin
        case (op)
          1: if (first) begin
               if (ptr < NUM_REGS) begin m_regs[ptr] = tx_buf[i]; m_strobe++; end
               first = 1'b0;
             end
          2: exp_rx[i] = (i == 1) ? m_read(ptr) : 8'h00;
          3: begin
               if (ptr < NUM_REGS) begin m_regs[ptr] = tx_buf[i]; m_strobe++; end
               if (ptr < 15) ptr++;
             end
          4: begin
               exp_rx[i] = m_read(ptr);
               if (ptr < 15) ptr++;
             end
          default: ;
        endcase
      end
    end
    if (aborted) m_err++;
  endtask

  task automatic do_frame(input int nbytes, input int extra, input bit do_reset);
    int total;
    int nb;
    check_en = 1'b0;
    total = nbytes + ((extra > 0) ? 1 : 0);
    ss = 1'b0;
    wait_clk(6);
    for (int i = 0; i < total; i++) begin
      nb = (i < nbytes) ? 8 : extra;
      for (int b = 0; b < nb; b++) begin
        sclk = 1'b0;
        mosi = tx_buf[i][7-b];
        wait_clk(6);
        rx_buf[i][7-b] = miso;
        sclk = 1'b1;
        wait_clk(6);
      end
    end
    if (do_reset) begin
      rst_n = 1'b0;
      ss    = 1'b1;
      sclk  = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
    end else begin
      ss = 1'b1;
    end
    wait_clk(12);
    model_frame(nbytes, (extra > 0) && !do_reset);
    if (do_reset) for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    for (int i = 0; i < nbytes; i++) check("miso_byte", rx_buf[i], exp_rx[i]);
    check("strobe_count", n_strobe, m_strobe);
    check("frame_err_count", n_err, m_err);
    $display("frame %0d: cmd=%02h bytes=%0d partial_bits=%0d reset=%0d rx1=%02h strobes=%0d errs=%0d",
             frame_no, tx_buf[0], nbytes, extra, do_reset, rx_buf[1], n_strobe, n_err);
    frame_no++;
    check_en = 1'b1;
    wait_clk(5);
  endtask

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_strobe++;
    if (frame_err === 1'b1) n_err++;
  end

  // Between frames every output must match the model and be idle.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) exp_value[4*k +: 4] = m_regs[k+1][3:0];
      check("display_value", disp_value, exp_value);
      check("display_point", disp_point, m_regs[NUM_REGS-1]);
      check("display_enable", disp_enable, m_regs[0]);
      check("miso_idle", miso, 1'b1);
      check("wr_strobe_idle", wr_strobe, 1'b0);
      check("frame_err_idle", frame_err, 1'b0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sclk = 1'b1; ss = 1'b1; mosi = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    wait_clk(5);
    check("reset_value", disp_value, 32'h0);
    check("reset_miso", miso, 1'b1);
    check("reset_strobe", wr_strobe, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);
    check("post_reset_enable", disp_enable, 8'h00);
    check("post_reset_err", frame_err, 1'b0);

    // Single write
    tx_buf[0] = 8'h13; tx_buf[1] = 8'hA5;
    do_frame(2, 0, 1'b0);
    check("digit3_nibble", disp_value[11:8], 4'h5);

    // Burst write of the whole map
    tx_buf[0] = 8'h30; tx_buf[1] = 8'hFF;
    for (int i = 1; i <= NUM_DIGITS; i++) tx_buf[i+1] = 8'(i);
    tx_buf[NUM_DIGITS+2] = 8'h5A;
    do_frame(NUM_DIGITS + 3, 0, 1'b0);
    check("burst_enable", disp_enable, 8'hFF);
    check("burst_value", disp_value, 32'h87654321);
    check("burst_point", disp_point, 8'h5A);

    // Single read and burst reads
    tx_buf[0] = 8'h25; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    do_frame(3, 0, 1'b0);
    check("read_reg5", rx_buf[1], 8'h05);
    tx_buf[0] = 8'h4E; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    do_frame(3, 0, 1'b0);
    check("read_out_of_range", rx_buf[1], 8'h00);
    tx_buf[0] = 8'h47; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    do_frame(4, 0, 1'b0);
    check("burst_read_radix", rx_buf[3], 8'h5A);

    // Out-of-range write, saturating burst write, NOP
    tx_buf[0] = 8'h1C; tx_buf[1] = 8'h77;
    do_frame(2, 0, 1'b0);
    tx_buf[0] = 8'h3E; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    do_frame(4, 0, 1'b0);
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h99;
    do_frame(2, 0, 1'b0);

    // Abort after 4 data bits, then a clean write
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h3C;
    do_frame(1, 4, 1'b0);
    check("abort_keeps_digit1", disp_value[3:0], 4'h1);
    do_frame(2, 0, 1'b0);
    check("write_after_abort", disp_value[3:0], 4'hC);

    // Illegal opcode
    tx_buf[0] = 8'h93; tx_buf[1] = 8'h55;
    do_frame(2, 0, 1'b0);
    check("illegal_no_write", disp_value[11:8], 4'h3);

    // Reset in the middle of a burst write
    tx_buf[0] = 8'h30; tx_buf[1] = 8'h0F; tx_buf[2] = 8'h09; tx_buf[3] = 8'hEE;
    do_frame(3, 4, 1'b1);
    check("mid_reset_value", disp_value, 32'h0);
    check("mid_reset_enable", disp_enable, 8'h00);
    check("mid_reset_miso", miso, 1'b1);

    check_en = 1'b0;
    wait_clk(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
